dcache_stb_port: RTL and testbench
==================================

DCACHE_STB_PORT -- requirements
Module: dcache_stb_port

Interface
REQ-001 SHALL have parameter NUM_LINES, default NUM_CACHE_LINES, number of direct-mapped lines (power of 2, >=2).
REQ-002 SHALL have parameter LINE_WIDTH, default 128, line size in bits (4 words).
REQ-003 SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port stb_write_in  input  1  STB drain request (valid).
REQ-006 SHALL have port stb_addr_in  input  ADDRESS_WIDTH  drain byte address.
REQ-007 SHALL have port stb_data_in  input  XLEN  drain data (byte in bits [7:0] when size B).
REQ-008 SHALL have port stb_size_in  input  data_size_e  B or W.
REQ-009 SHALL have port stb_ready_out  output  1  drain accepted this cycle when high with stb_write_in.
REQ-010 SHALL have ports ld_addr_in  input  ADDRESS_WIDTH, ld_hit_out  output  1, ld_data_out  output  XLEN  combinational load lookup.
REQ-011 SHALL have ports mem_req_out  output  1, mem_we_out  output  1, mem_addr_out  output  ADDRESS_WIDTH, mem_wdata_out  output  LINE_WIDTH  line request to memory arbiter.
REQ-012 SHALL have ports mem_rdata_in  input  LINE_WIDTH, mem_valid_in  input  1  memory completion (one-cycle pulse).

Function
REQ-013 SHALL split address: offset [3:0], index [3+clog2(NUM_LINES):4], tag remaining upper bits; per line store valid, dirty, tag, data.
REQ-014 SHALL implement FSM states IDLE, WRITEBACK, FILL, MERGE; stb_ready_out = (state==IDLE).
REQ-015 IDLE, stb_write_in & hit: SHALL write byte lane addr[1:0] (B) or word addr[3:2] (W, addr[1:0] ignored) at clock edge, set dirty, stay IDLE; one drain per cycle, zero stall.
REQ-016 IDLE, stb_write_in & miss: SHALL capture addr/data/size into pending register; go WRITEBACK if victim valid&dirty, else FILL.
REQ-017 WRITEBACK: SHALL drive mem_req_out=1, mem_we_out=1, mem_addr_out={victim tag,index,4'b0}, mem_wdata_out=victim line; on mem_valid_in go FILL.
REQ-018 FILL: SHALL drive mem_req_out=1, mem_we_out=0, mem_addr_out={pending tag,index,4'b0}; on mem_valid_in latch mem_rdata_in into line, set valid, tag, clear dirty, go MERGE.
REQ-019 MERGE: SHALL apply pending store per REQ-015 lane rules, set dirty, return IDLE (mem_req_out=0); miss penalty = memory latency(ies) + 1 cycle.
REQ-020 mem_req_out and address SHALL hold stable until mem_valid_in; mem_valid_in in IDLE/MERGE SHALL be ignored.
REQ-021 ld_hit_out SHALL be valid&tag-match in IDLE only, 0 in other states; ld_data_out = word addr[3:2] of indexed line, regardless of hit.
REQ-022 Load and store to same word in same IDLE cycle: load SHALL return pre-store data.
REQ-023 stb_write_in with stb_ready_out low SHALL have no effect; STB holds request.

Reset
REQ-024 Reset SHALL clear all valid and dirty bits, state=IDLE, pending register cleared; data/tag arrays need not reset.
REQ-025 While reset high: stb_ready_out=0, mem_req_out=0, mem_we_out=0, ld_hit_out=0; after release stb_ready_out=1.
REQ-026 Reset mid-WRITEBACK/FILL/MERGE SHALL abort transaction and drop pending store; mem_req_out low next cycle.

Configuration
REQ-027 With DCACHE_PERF_CNT_EN defined: SHALL add outputs hit_cnt_out and miss_cnt_out (32 bits each), incremented per accepted hit drain / per miss entry, saturating at all-ones, cleared by reset.
REQ-028 Without DCACHE_PERF_CNT_EN: counter ports and logic SHALL be absent; all other behaviour identical.

Verification (NUM_LINES=4, index=addr[5:4])
REQ-029 Reset, drain W 0x100 data 0xDEADBEEF, mem returns line 0 after 3 cycles -> FILL req addr 0x100 we=0, MERGE, then ld 0x100 hit data 0xDEADBEEF, stb_ready low 5 cycles.
REQ-030 Drain B 0x102 data 0xAA to line from REQ-029 -> ready stays high, ld 0x100 data 0xDEAABEEF.
REQ-031 Drain W 0x200 (same index, dirty victim) -> WRITEBACK addr 0x100 wdata containing 0xDEAABEEF, then FILL addr 0x200, ld 0x100 miss.
REQ-032 Back-to-back hit drains 0x200,0x204,0x208,0x20C, one per cycle -> all accepted, no mem_req_out.
REQ-033 Reset asserted during FILL -> mem_req_out 0 next cycle, ld 0x200 miss, stb_ready_out 1 after release.
REQ-034 With DCACHE_PERF_CNT_EN: REQ-029..032 sequence -> hit_cnt_out 5, miss_cnt_out 2.

Source files
------------

// File: rtl/dcache_stb_port.sv
// Direct-mapped write-back data cache port that drains a store buffer one store per cycle.
// Define DCACHE_PERF_CNT_EN to add saturating hit/miss counter outputs.
`ifndef NUM_CACHE_LINES
`define NUM_CACHE_LINES 4
`endif

module dcache_stb_port #(
    parameter int unsigned NUM_LINES     = `NUM_CACHE_LINES,
    parameter int unsigned LINE_WIDTH    = 128,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned XLEN          = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stb_write_in,
    input  logic [ADDRESS_WIDTH-1:0] stb_addr_in,
    input  logic [XLEN-1:0]          stb_data_in,
    input  logic                     stb_size_in,   // 0 = byte (B), 1 = word (W)
    output logic                     stb_ready_out,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr_in,
    output logic                     ld_hit_out,
    output logic [XLEN-1:0]          ld_data_out,
    output logic                     mem_req_out,
    output logic                     mem_we_out,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_out,
    output logic [LINE_WIDTH-1:0]    mem_wdata_out,
    input  logic [LINE_WIDTH-1:0]    mem_rdata_in,
    input  logic                     mem_valid_in
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]              hit_cnt_out,
    output logic [31:0]              miss_cnt_out
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDRESS_WIDTH - 4 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, MERGE} state_e;

    state_e state_q, state_d;

    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [LINE_WIDTH-1:0] data_q [NUM_LINES];

    logic [ADDRESS_WIDTH-1:0] pend_addr_q;
    logic [XLEN-1:0]          pend_data_q;
    logic                     pend_size_q;

    logic [IDX_W-1:0] stb_idx, pend_idx, ld_idx;
    logic [TAG_W-1:0] stb_tag, pend_tag, ld_tag;
    logic             idle, stb_hit, drain_hit, drain_miss, fill_done, merge_go;
    logic             unused_ld_bits;

    function automatic logic [LINE_WIDTH-1:0] merge_store(
        input logic [LINE_WIDTH-1:0] line,
        input logic [3:0]            offs,
        input logic [XLEN-1:0]       data,
        input logic                  size_w
    );
        logic [LINE_WIDTH-1:0] r;
        r = line;
        if (size_w)
            r[32'(offs[3:2]) * XLEN +: XLEN] = data;
        else
            r[32'(offs) * 8 +: 8] = data[7:0];
        return r;
    endfunction

    assign stb_idx  = stb_addr_in[4 +: IDX_W];
    assign stb_tag  = stb_addr_in[ADDRESS_WIDTH-1 -: TAG_W];
    assign pend_idx = pend_addr_q[4 +: IDX_W];
    assign pend_tag = pend_addr_q[ADDRESS_WIDTH-1 -: TAG_W];
    assign ld_idx   = ld_addr_in[4 +: IDX_W];
    assign ld_tag   = ld_addr_in[ADDRESS_WIDTH-1 -: TAG_W];
    assign unused_ld_bits = ^ld_addr_in[1:0];

    // Gating with reset keeps all handshake outputs low for the whole reset assertion.
    assign idle       = (state_q == IDLE) && !reset;
    assign stb_hit    = valid_q[stb_idx] && (tag_q[stb_idx] == stb_tag);
    assign drain_hit  = stb_write_in && idle && stb_hit;
    assign drain_miss = stb_write_in && idle && !stb_hit;
    assign fill_done  = (state_q == FILL) && mem_valid_in && !reset;
    assign merge_go   = (state_q == MERGE) && !reset;

    assign stb_ready_out = idle;
    assign ld_hit_out    = idle && valid_q[ld_idx] && (tag_q[ld_idx] == ld_tag);
    assign ld_data_out   = data_q[ld_idx][32'(ld_addr_in[3:2]) * XLEN +: XLEN];

    always_comb begin
        state_d       = state_q;
        mem_req_out   = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        unique case (state_q)
            IDLE: begin
                if (drain_miss)
                    state_d = (valid_q[stb_idx] && dirty_q[stb_idx]) ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
                mem_req_out   = 1'b1;
                mem_we_out    = 1'b1;
                mem_addr_out  = {tag_q[pend_idx], pend_idx, 4'b0};
                mem_wdata_out = data_q[pend_idx];
                if (mem_valid_in)
                    state_d = FILL;
            end
            FILL: begin
                mem_req_out  = 1'b1;
                mem_addr_out = {pend_tag, pend_idx, 4'b0};
                if (mem_valid_in)
                    state_d = MERGE;
            end
            MERGE: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            state_d     = IDLE;
            mem_req_out = 1'b0;
            mem_we_out  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_size_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (drain_miss) begin
                pend_addr_q <= stb_addr_in;
                pend_data_q <= stb_data_in;
                pend_size_q <= stb_size_in;
            end
            if (drain_hit)
                dirty_q[stb_idx] <= 1'b1;
            if (fill_done) begin
                valid_q[pend_idx] <= 1'b1;
                dirty_q[pend_idx] <= 1'b0;
            end
            if (merge_go)
                dirty_q[pend_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; validity alone decides whether contents are used.
    always_ff @(posedge clk) begin
        if (drain_hit)
            data_q[stb_idx] <= merge_store(data_q[stb_idx], stb_addr_in[3:0],
                                           stb_data_in, stb_size_in);
        if (fill_done) begin
            data_q[pend_idx] <= mem_rdata_in;
            tag_q[pend_idx]  <= pend_tag;
        end
        if (merge_go)
            data_q[pend_idx] <= merge_store(data_q[pend_idx], pend_addr_q[3:0],
                                            pend_data_q, pend_size_q);
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (drain_hit && (hit_cnt_q != '1))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (drain_miss && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_out  = hit_cnt_q;
    assign miss_cnt_out = miss_cnt_q;
`else
    // Counter outputs and state are not built in this configuration.
`endif

endmodule

// File: tb/tb_dcache_stb_port.sv
// Self-checking bench for dcache_stb_port: directed scenarios then randomized drains/loads
// against a byte-level memory + line-residency reference model.
module tb_dcache_stb_port;

    logic         clk = 1'b0;
    logic         reset;
    logic         stb_write_in;
    logic [31:0]  stb_addr_in;
    logic [31:0]  stb_data_in;
    logic         stb_size_in;
    logic         stb_ready_out;
    logic [31:0]  ld_addr_in;
    logic         ld_hit_out;
    logic [31:0]  ld_data_out;
    logic         mem_req_out;
    logic         mem_we_out;
    logic [31:0]  mem_addr_out;
    logic [127:0] mem_wdata_out;
    logic [127:0] mem_rdata_in;
    logic         mem_valid_in;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt_out;
    logic [31:0]  miss_cnt_out;
`endif

    dcache_stb_port #(.NUM_LINES(4), .LINE_WIDTH(128), .ADDRESS_WIDTH(32), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .stb_write_in(stb_write_in), .stb_addr_in(stb_addr_in), .stb_data_in(stb_data_in),
        .stb_size_in(stb_size_in), .stb_ready_out(stb_ready_out),
        .ld_addr_in(ld_addr_in), .ld_hit_out(ld_hit_out), .ld_data_out(ld_data_out),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in), .mem_valid_in(mem_valid_in)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_cnt_out(hit_cnt_out), .miss_cnt_out(miss_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: backing memory as bytes, plus which line base each set holds.
    logic [7:0] mem_b [int unsigned];
    int         res_line [4];
    logic [7:0] cl [4][16];
    int         n_hit = 0;
    int         n_miss = 0;

    function automatic logic [7:0] mem_rd(input int unsigned a);
        return mem_b.exists(a) ? mem_b[a] : 8'(a * 13 + 5);
    endfunction

    function automatic logic [127:0] mem_line(input int unsigned base);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = mem_rd(base + i);
        return l;
    endfunction

    function automatic logic [127:0] cache_line(input int idx);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = cl[idx][i];
        return l;
    endfunction

    function automatic logic [31:0] model_word(input int idx, input int unsigned a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = cl[idx][int'(a & 12) + k];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One memory transaction: request must be stable for lat cycles, completion in the last one.
    task automatic serve(input bit we, input int unsigned addr, input logic [127:0] wdata,
                         input int lat, inout int stall, output logic [127:0] cap);
        cap = '0;
        for (int c = 0; c < lat; c++) begin
            #1;
            chk(we ? "wb_req" : "fill_req", mem_req_out, 1'b1);
            chk(we ? "wb_we" : "fill_we", mem_we_out, we);
            chk(we ? "wb_addr" : "fill_addr", mem_addr_out, addr);
            if (we) chk("wb_wdata", mem_wdata_out, wdata);
            chk("busy_ready", stb_ready_out, 1'b0);
            chk("busy_ld_hit", ld_hit_out, 1'b0);
            stall++;
            if (c == lat - 1) begin
                cap          = mem_wdata_out;
                mem_valid_in = 1'b1;
                mem_rdata_in = we ? 128'h0 : mem_line(addr);
            end
            @(posedge clk);
            @(negedge clk);
            mem_valid_in = 1'b0;
            mem_rdata_in = '0;
        end
    endtask

    task automatic do_store(input int unsigned a, input logic [31:0] d, input logic sz,
                            input int lat_wb, input int lat_fill, output int stall);
        int           idx;
        bit           hit;
        int unsigned  base;
        logic [127:0] cap;
        idx   = int'((a >> 4) & 3);
        hit   = (res_line[idx] == int'(a >> 4));
        base  = a & 32'hFFFF_FFF0;
        stall = 0;
        stb_write_in = 1'b1; stb_addr_in = a; stb_data_in = d; stb_size_in = sz;
        ld_addr_in = a;
        #1;
        chk("drain_ready", stb_ready_out, 1'b1);
        chk("drain_ld_hit", ld_hit_out, hit);
        if (hit) begin
            chk("pre_store_ld_data", ld_data_out, model_word(idx, a));
            chk("hit_no_memreq", mem_req_out, 1'b0);
            n_hit++;
        end else begin
            n_miss++;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hit) begin
            // A different request held by the STB while stalled must have no effect.
            stb_addr_in = a ^ 32'h40;
            stb_data_in = ~d;
            if (res_line[idx] >= 0) begin
                int unsigned wb_base;
                wb_base = int'(res_line[idx]) << 4;
                serve(1'b1, wb_base, cache_line(idx), lat_wb, stall, cap);
                for (int i = 0; i < 16; i++) mem_b[wb_base + i] = cap[8*i +: 8];
            end
            serve(1'b0, base, '0, lat_fill, stall, cap);
            for (int i = 0; i < 16; i++) cl[idx][i] = mem_rd(base + i);
            res_line[idx] = int'(a >> 4);
            #1;
            chk("merge_ready", stb_ready_out, 1'b0);
            chk("merge_memreq", mem_req_out, 1'b0);
            stall++;
            @(posedge clk);
            @(negedge clk);
        end
        stb_write_in = 1'b0;
        if (sz) for (int k = 0; k < 4; k++) cl[idx][int'(a & 12) + k] = d[8*k +: 8];
        else    cl[idx][int'(a & 15)] = d[7:0];
        #1;
        chk("ready_after_drain", stb_ready_out, 1'b1);
    endtask

    task automatic check_load(input int unsigned a);
        int idx;
        bit hit;
        idx = int'((a >> 4) & 3);
        hit = (res_line[idx] == int'(a >> 4));
        ld_addr_in = a;
        #1;
        chk("ld_hit", ld_hit_out, hit);
        if (hit) chk("ld_data", ld_data_out, model_word(idx, a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    stall;
        time   t0;
        for (int i = 0; i < 4; i++) res_line[i] = -1;
        reset = 1'b1; stb_write_in = 1'b0; stb_addr_in = '0; stb_data_in = '0;
        stb_size_in = 1'b0; ld_addr_in = 32'h100; mem_rdata_in = '0; mem_valid_in = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", stb_ready_out, 1'b0);
        chk("rst_memreq", mem_req_out, 1'b0);
        chk("rst_memwe", mem_we_out, 1'b0);
        chk("rst_ld_hit", ld_hit_out, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", stb_ready_out, 1'b1);

        // Word drain miss; memory answers on the fourth request cycle -> 5 stall cycles.
        @(negedge clk);
        do_store(32'h100, 32'hDEAD_BEEF, 1'b1, 1, 4, stall);
        chk("miss_stall_cycles", stall, 5);
        check_load(32'h100);
        chk("ld_0x100_word", ld_data_out, 32'hDEAD_BEEF);

        do_store(32'h102, 32'h0000_00AA, 1'b0, 1, 1, stall);
        chk("byte_hit_stall", stall, 0);
        check_load(32'h100);
        chk("ld_0x100_byte", ld_data_out, 32'hDEAA_BEEF);

        @(negedge clk);
        do_store(32'h200, 32'h1234_5678, 1'b1, 2, 2, stall);
        chk("wb_fill_stall", stall, 5);
        chk("wb_word_0x100", {mem_b[32'h103], mem_b[32'h102], mem_b[32'h101], mem_b[32'h100]},
            32'hDEAA_BEEF);
        check_load(32'h100);
        chk("ld_0x100_evicted", ld_hit_out, 1'b0);

        @(negedge clk);
        t0 = $time;
        do_store(32'h200, 32'hA0A0_0001, 1'b1, 1, 1, stall);
        do_store(32'h204, 32'hA0A0_0002, 1'b1, 1, 1, stall);
        do_store(32'h208, 32'hA0A0_0003, 1'b1, 1, 1, stall);
        do_store(32'h20C, 32'hA0A0_0004, 1'b1, 1, 1, stall);
        chk("b2b_drain_time", 64'($time - t0), 64'd41);
        check_load(32'h20C);

        // A stray completion while idle must not disturb the cache.
        @(negedge clk);
        mem_valid_in = 1'b1; mem_rdata_in = '1;
        @(posedge clk);
        @(negedge clk);
        mem_valid_in = 1'b0; mem_rdata_in = '0;
        check_load(32'h208);
        chk("idle_valid_ready", stb_ready_out, 1'b1);

`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt", hit_cnt_out, 32'd5);
        chk("miss_cnt", miss_cnt_out, 32'd2);
`endif

        // Reset while FILL is outstanding aborts it and drops the pending store.
        @(negedge clk);
        stb_write_in = 1'b1; stb_addr_in = 32'h310; stb_data_in = 32'h5555_5555; stb_size_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stb_write_in = 1'b0;
        #1;
        chk("abort_fill_req", mem_req_out, 1'b1);
        chk("abort_fill_addr", mem_addr_out, 32'h310);
        reset = 1'b1; ld_addr_in = 32'h200;
        #1;
        chk("abort_rst_ready", stb_ready_out, 1'b0);
        chk("abort_rst_memreq", mem_req_out, 1'b0);
        chk("abort_rst_ld_hit", ld_hit_out, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("abort_next_memreq", mem_req_out, 1'b0);
        reset = 1'b0;
        #1;
        chk("abort_post_ready", stb_ready_out, 1'b1);
        chk("abort_post_memreq", mem_req_out, 1'b0);
        chk("abort_ld_0x200_miss", ld_hit_out, 1'b0);
        for (int i = 0; i < 4; i++) res_line[i] = -1;
        n_hit = 0; n_miss = 0;
`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt_rst", hit_cnt_out, 32'd0);
        chk("miss_cnt_rst", miss_cnt_out, 32'd0);
`endif

        // Randomized drains over 16 conflicting lines, with random loads between them.
        @(negedge clk);
        for (int n = 0; n < 200; n++) begin
            int unsigned a;
            a = $urandom_range(0, 1023);
            do_store(a, $urandom, 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), stall);
            check_load($urandom_range(0, 1023));
            check_load(a);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end

`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt_rand", hit_cnt_out, 32'(n_hit));
        chk("miss_cnt_rand", miss_cnt_out, 32'(n_miss));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
